// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and load/store (DM).
// DM has fixed priority, bounded by a starvation guard that forces an IF grant after STARVE_MAX DM grants.
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [3:0]        dm_be,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ack,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner_dm,
    output logic              busy
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);
    localparam int TC_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [SC_W-1:0]   starve_q, starve_d;
    logic [TC_W-1:0]   tmo_q, tmo_d;
    logic              owner_dm_q, owner_dm_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
    logic              if_err_q, if_err_d, dm_err_q, dm_err_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic              grant_dm_s, grant_if_s;
    logic [DATA_W-1:0] resp_data_s;
    logic              resp_err_s;
    logic              resp_s;

    // Next-state, grant and response computation
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        owner_dm_d  = owner_dm_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        grant_dm_s  = 1'b0;
        grant_if_s  = 1'b0;
        resp_s      = 1'b0;
        resp_data_s = {DATA_W{1'b0}};
        resp_err_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (dm_req && !(if_req && (starve_q == SC_W'(STARVE_MAX)))) begin
                    grant_dm_s  = 1'b1;
                    owner_dm_d  = 1'b1;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_req_d   = 1'b1;
                    tmo_d       = {TC_W{1'b0}};
                    state_d     = ST_ISSUE;
                end else if (if_req) begin
                    grant_if_s  = 1'b1;
                    owner_dm_d  = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_be_d    = 4'hF;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = {DATA_W{1'b0}};
                    tmo_d       = {TC_W{1'b0}};
                    // A misaligned fetch never touches memory and errors out immediately
                    if (if_addr[1:0] != 2'b00) begin
                        resp_s     = 1'b1;
                        resp_err_s = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (mem_ready) begin
                    resp_s      = 1'b1;
                    resp_data_s = mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
                    mem_req_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_q == TC_W'(TIMEOUT - 1)) begin
                    resp_s     = 1'b1;
                    resp_err_s = 1'b1;
                    mem_req_d  = 1'b0;
                    state_d    = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TC_W'(1);
                end
            end
            ST_RESP: begin
                tmo_d   = {TC_W{1'b0}};
                state_d = ST_IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                tmo_d     = {TC_W{1'b0}};
                state_d   = ST_IDLE;
            end
        endcase

        if_ack_d   = resp_s && !owner_dm_d;
        dm_ack_d   = resp_s && owner_dm_d;
        if_rdata_d = if_ack_d ? resp_data_s : {DATA_W{1'b0}};
        dm_rdata_d = dm_ack_d ? resp_data_s : {DATA_W{1'b0}};
        if_err_d   = if_ack_d && resp_err_s;
        dm_err_d   = dm_ack_d && resp_err_s;

        // Starvation counter saturates at STARVE_MAX; the IF grant at that value clears it
        if (!if_req) begin
            starve_d = {SC_W{1'b0}};
        end else if (grant_dm_s) begin
            starve_d = (starve_q == SC_W'(STARVE_MAX)) ? starve_q : starve_q + SC_W'(1);
        end else if (grant_if_s) begin
            starve_d = {SC_W{1'b0}};
        end else begin
            starve_d = starve_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            starve_q    <= {SC_W{1'b0}};
            tmo_q       <= {TC_W{1'b0}};
            owner_dm_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= 4'h0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_err_q    <= 1'b0;
            dm_err_q    <= 1'b0;
            if_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            tmo_q       <= tmo_d;
            owner_dm_q  <= owner_dm_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            if_err_q    <= if_err_d;
            dm_err_q    <= dm_err_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_rdata  = if_rdata_q;
    assign if_err    = if_err_q;
    assign dm_ack    = dm_ack_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_err    = dm_err_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign owner_dm  = owner_dm_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
